// File: rtl/ddr_init_pkg.sv
// Shared types and constants for the DDR3 power-up initialisation sequencer.
package ddr_init_pkg;

    // Sequencer states, in the order the DRAM walks through them.
    typedef enum logic [3:0] {
        IDLE,
        RST_HOLD,
        CKE_WAIT,
        XPR_WAIT,
        MRS2,
        MRS3,
        MRS1,
        MRS0,
        MOD_WAIT,
        ZQCL,
        DONE
    } init_state_e;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_ZQCL  = 4'b0110;
    // Chip deselected: used while the DRAM is held in reset or CKE is low.
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    // Address bit that selects the long ZQ calibration.
    localparam int ZQCL_A10 = 10;

    // A programmed delay of zero still occupies one cycle.
    function automatic int unsigned eff_dly(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/ddr_init_seq_if.sv
// Start/done handshake plus the DFI command/control bundle owned by the sequencer.
interface ddr_init_seq_if #(
    parameter int ADDR_W = 14,
    parameter int BANK_W = 3
);
    logic              ddr_init_start;
    logic              ddr_init_done;
    logic              dfi_reset_n;
    logic              dfi_cke;
    logic              dfi_cs_n;
    logic              dfi_ras_n;
    logic              dfi_cas_n;
    logic              dfi_we_n;
    logic [BANK_W-1:0] dfi_bank;
    logic [ADDR_W-1:0] dfi_address;
    logic              dfi_odt;

    // Sequencer side: drives the DRAM, answers the controller.
    modport master (
        input  ddr_init_start,
        output ddr_init_done, dfi_reset_n, dfi_cke,
        output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
        output dfi_bank, dfi_address, dfi_odt
    );

    // Controller/PHY side: requests the sequence, observes the DFI bundle.
    modport slave (
        output ddr_init_start,
        input  ddr_init_done, dfi_reset_n, dfi_cke,
        input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
        input  dfi_bank, dfi_address, dfi_odt
    );
endinterface

// File: rtl/init_delay_cnt.sv
// Down-counter for state dwell times: load N-1, count to zero, hold at zero.
module init_delay_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;

    // Load on state entry, otherwise decrement and saturate at zero.
    always_ff @(posedge core_clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (core_rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ddr_init_seq.sv
// DDR3 power-up sequencer: reset, CKE, MRS2/3/1/0, ZQCL, then done.
module ddr_init_seq
    import ddr_init_pkg::*;
#(
    parameter int              ADDR_W   = 14,
    parameter int              BANK_W   = 3,
    parameter int              CNT_W    = 20,
    parameter int unsigned     T_RESET  = 50000,
    parameter int unsigned     T_CKE    = 125000,
    parameter int unsigned     T_XPR    = 64,
    parameter int unsigned     T_MRD    = 4,
    parameter int unsigned     T_MOD    = 12,
    parameter int unsigned     T_ZQINIT = 512,
    parameter logic [ADDR_W-1:0] MR0    = '0,
    parameter logic [ADDR_W-1:0] MR1    = '0,
    parameter logic [ADDR_W-1:0] MR2    = '0,
    parameter logic [ADDR_W-1:0] MR3    = '0
) (
    input  logic          core_clk,
    input  logic          core_rst,
    ddr_init_seq_if.master bus
);
    init_state_e       state_q, state_d;
    logic              cnt_zero;
    logic              entering;
    logic [CNT_W-1:0]  load_val;
    logic              reset_n_d, cke_d, done_d;
    logic [3:0]        cmd_d;
    logic [BANK_W-1:0] bank_d;
    logic [ADDR_W-1:0] addr_d;

    // With a one-cycle MOD window, ZQCL follows MRS0 directly.
    localparam bit SKIP_MOD = (eff_dly(T_MOD) == 1);

    init_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .load     (entering),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge core_clk) begin
        if (core_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, dwell load value and next-cycle output levels.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        load_val  = '0;
        if (state_q != IDLE && !bus.ddr_init_start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (bus.ddr_init_start) state_d = RST_HOLD;
                RST_HOLD: if (cnt_zero) state_d = CKE_WAIT;
                CKE_WAIT: if (cnt_zero) state_d = XPR_WAIT;
                XPR_WAIT: if (cnt_zero) state_d = MRS2;
                MRS2:     if (cnt_zero) state_d = MRS3;
                MRS3:     if (cnt_zero) state_d = MRS1;
                MRS1:     if (cnt_zero) state_d = MRS0;
                MRS0:     if (cnt_zero) state_d = SKIP_MOD ? ZQCL : MOD_WAIT;
                MOD_WAIT: if (cnt_zero) state_d = ZQCL;
                ZQCL:     if (cnt_zero) state_d = DONE;
                DONE:     state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end

        entering = (state_d != state_q);

        case (state_d)
            RST_HOLD:           load_val = CNT_W'(eff_dly(T_RESET) - 1);
            CKE_WAIT:           load_val = CNT_W'(eff_dly(T_CKE) - 1);
            XPR_WAIT:           load_val = CNT_W'(eff_dly(T_XPR) - 1);
            MRS2, MRS3, MRS1:   load_val = CNT_W'(eff_dly(T_MRD) - 1);
            MOD_WAIT:           load_val = CNT_W'(eff_dly(T_MOD) - 2);
            ZQCL:               load_val = CNT_W'(eff_dly(T_ZQINIT) - 1);
            default:            load_val = '0;
        endcase

        reset_n_d = !(state_d inside {IDLE, RST_HOLD});
        cke_d     = !(state_d inside {IDLE, RST_HOLD, CKE_WAIT});
        done_d    = (state_d == DONE);
        cmd_d     = cke_d ? CMD_NOP : CMD_DESEL;
        bank_d    = '0;
        addr_d    = '0;
        // Commands occupy only the first cycle of their state.
        if (entering) begin
            case (state_d)
                MRS2: begin cmd_d = CMD_MRS; bank_d = BANK_W'(2); addr_d = MR2; end
                MRS3: begin cmd_d = CMD_MRS; bank_d = BANK_W'(3); addr_d = MR3; end
                MRS1: begin cmd_d = CMD_MRS; bank_d = BANK_W'(1); addr_d = MR1; end
                MRS0: begin cmd_d = CMD_MRS; bank_d = BANK_W'(0); addr_d = MR0; end
                ZQCL: begin cmd_d = CMD_ZQCL; addr_d[ZQCL_A10] = 1'b1; end
                default: ;
            endcase
        end
    end

    // Registered DFI outputs and done flag.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            bus.ddr_init_done <= 1'b0;
            bus.dfi_reset_n   <= 1'b0;
            bus.dfi_cke       <= 1'b0;
            {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n} <= CMD_DESEL;
            bus.dfi_bank      <= '0;
            bus.dfi_address   <= '0;
            bus.dfi_odt       <= 1'b0;
        end else begin
            bus.ddr_init_done <= done_d;
            bus.dfi_reset_n   <= reset_n_d;
            bus.dfi_cke       <= cke_d;
            {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n} <= cmd_d;
            bus.dfi_bank      <= bank_d;
            bus.dfi_address   <= addr_d;
            bus.dfi_odt       <= 1'b0;
        end
    end
endmodule
